lsu_bus_adapter: RTL

- Parametrised load/store unit between the MEM pipeline stage and the data bus.
- Replaces the single-cycle bus access with a request/acknowledge handshake, so slaves may insert wait states.
- Adds alignment checking, byte-lane steering, load sign/zero extension, bus-error and timeout faults, and a stall output to freeze the pipeline.
- Supports XLEN 32 or 64; doubleword and LWU accesses exist only for XLEN=64.

---
 rtl/lsu_pkg.sv | 41 ++++
 rtl/lsu_bus_adapter_if.sv | 38 +++
 rtl/lsu_lane_align.sv | 45 ++++
 rtl/lsu_bus_adapter.sv | 122 ++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store bus adapter: op/size codes, fault codes,
// FSM states and the per-size byte mask.
package lsu_pkg;

  localparam logic [1:0] MEM_OP_NONE  = 2'b00;
  localparam logic [1:0] MEM_OP_LOAD  = 2'b01;
  localparam logic [1:0] MEM_OP_STORE = 2'b10;
  localparam logic [1:0] MEM_OP_RSVD  = 2'b11;

  localparam logic [2:0] MEM_SEL_B  = 3'b000;
  localparam logic [2:0] MEM_SEL_H  = 3'b001;
  localparam logic [2:0] MEM_SEL_W  = 3'b010;
  localparam logic [2:0] MEM_SEL_D  = 3'b011;
  localparam logic [2:0] MEM_SEL_BU = 3'b100;
  localparam logic [2:0] MEM_SEL_HU = 3'b101;
  localparam logic [2:0] MEM_SEL_WU = 3'b110;

  localparam logic [1:0] FAULT_OK  = 2'b00;
  localparam logic [1:0] FAULT_ILL = 2'b01;
  localparam logic [1:0] FAULT_BUS = 2'b10;
  localparam logic [1:0] FAULT_TMO = 2'b11;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_RESP = 2'd2} lsu_state_e;

  // Control fields of an accepted request, held for the whole bus cycle
  typedef struct packed {
    logic       is_load;
    logic [2:0] sel;
    logic [4:0] rd;
  } lsu_ctl_t;

  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   return 8'h01;
      2'b01:   return 8'h03;
      2'b10:   return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/lsu_bus_adapter_if.sv
// MEM-stage request/response and data-bus signals of the load/store adapter.
// master = adapter side, slave = pipeline + bus slave side.
interface lsu_bus_adapter_if #(parameter int XLEN = 32);
  localparam int LANES = XLEN / 8;

  logic             req_valid;
  logic             req_ready;
  logic [1:0]       mem_op;
  logic [2:0]       mem_sel;
  logic [XLEN-1:0]  addr;
  logic [XLEN-1:0]  wdata;
  logic [4:0]       rd_in;
  logic             resp_valid;
  logic [XLEN-1:0]  resp_rdata;
  logic [4:0]       resp_rd;
  logic [1:0]       resp_fault;
  logic             stall;
  logic             bus_req;
  logic             bus_re;
  logic [LANES-1:0] bus_we;
  logic [XLEN-1:0]  bus_addr;
  logic [XLEN-1:0]  bus_wdata;
  logic             bus_ack;
  logic             bus_err;
  logic [XLEN-1:0]  bus_rdata;

  modport master (
    input  req_valid, mem_op, mem_sel, addr, wdata, rd_in, bus_ack, bus_err, bus_rdata,
    output req_ready, resp_valid, resp_rdata, resp_rd, resp_fault, stall,
           bus_req, bus_re, bus_we, bus_addr, bus_wdata
  );

  modport slave (
    output req_valid, mem_op, mem_sel, addr, wdata, rd_in, bus_ack, bus_err, bus_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_rd, resp_fault, stall,
           bus_req, bus_re, bus_we, bus_addr, bus_wdata
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store data replication + write enables, and load data
// extraction with sign/zero extension.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int LANES = XLEN / 8,
  parameter int OFFW  = $clog2(LANES)
) (
  input  logic [2:0]       sel,
  input  logic [OFFW-1:0]  off,
  input  logic [XLEN-1:0]  wdata,
  input  logic [XLEN-1:0]  rdata,
  output logic [LANES-1:0] we,
  output logic [XLEN-1:0]  wdata_lane,
  output logic [XLEN-1:0]  rdata_ext
);
  logic [LANES-1:0][7:0] wb, rep;
  logic [XLEN-1:0]       sh;

  assign wb = wdata;
  assign we = LANES'(size_mask(sel[1:0])) << off;

  // Each lane repeats the low bytes of the datum so any offset sees it on its lanes
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign rep[i] = (sel[1:0] == 2'b00) ? wb[0]   :
                    (sel[1:0] == 2'b01) ? wb[i%2] :
                    (sel[1:0] == 2'b10) ? wb[i%4] : wb[i];
  end
  assign wdata_lane = rep;

  assign sh = rdata >> {off, 3'b000};

  always_comb begin
    case (sel)
      MEM_SEL_B:  rdata_ext = XLEN'($signed(sh[7:0]));
      MEM_SEL_H:  rdata_ext = XLEN'($signed(sh[15:0]));
      MEM_SEL_W:  rdata_ext = XLEN'($signed(sh[31:0]));
      MEM_SEL_BU: rdata_ext = XLEN'(sh[7:0]);
      MEM_SEL_HU: rdata_ext = XLEN'(sh[15:0]);
      MEM_SEL_WU: rdata_ext = XLEN'(sh[31:0]);
      default:    rdata_ext = sh;
    endcase
  end
endmodule

// File: rtl/lsu_bus_adapter.sv
// Load/store unit front end: turns MEM-stage accesses into req/ack bus cycles
// with alignment checks, lane steering, bus-error/timeout faults and stall.
module lsu_bus_adapter
  import lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input logic              clk,
  input logic              rst,
  lsu_bus_adapter_if.master lsu
);
  localparam int LANES = XLEN / 8;
  localparam int OFFW  = $clog2(LANES);
  localparam int CW    = $clog2(TIMEOUT);

  lsu_state_e       state, nstate;
  lsu_ctl_t         ctl_q;
  logic [OFFW-1:0]  off_q;
  logic [CW-1:0]    cnt;
  logic             bus_req_q, bus_re_q;
  logic [LANES-1:0] bus_we_q;
  logic [XLEN-1:0]  bus_addr_q, bus_wdata_q, rdata_q;
  logic [1:0]       fault_q;

  logic             is_ld, is_st, bad_req, start, term;
  logic [1:0]       term_fault;
  logic [2:0]       al_sel;
  logic [OFFW-1:0]  al_off;
  logic [LANES-1:0] al_we;
  logic [XLEN-1:0]  al_wdata, al_rdata;

  // Idle: steer the incoming store; busy: extract from the latched request
  assign al_sel = (state == ST_IDLE) ? lsu.mem_sel : ctl_q.sel;
  assign al_off = (state == ST_IDLE) ? lsu.addr[OFFW-1:0] : off_q;

  lsu_lane_align #(.XLEN(XLEN)) u_align (
    .sel(al_sel), .off(al_off), .wdata(lsu.wdata), .rdata(lsu.bus_rdata),
    .we(al_we), .wdata_lane(al_wdata), .rdata_ext(al_rdata)
  );

  always_comb begin
    is_ld   = lsu.mem_op == MEM_OP_LOAD;
    is_st   = lsu.mem_op == MEM_OP_STORE;
    bad_req = (lsu.mem_op == MEM_OP_RSVD) || (lsu.mem_sel == 3'b111)
           || ((XLEN == 32) && (lsu.mem_sel == MEM_SEL_D || lsu.mem_sel == MEM_SEL_WU))
           || (is_st && lsu.mem_sel[2])
           || (lsu.mem_sel[1:0] == 2'b01 && lsu.addr[0])
           || (lsu.mem_sel[1:0] == 2'b10 && lsu.addr[1:0] != 2'b00)
           || (lsu.mem_sel[1:0] == 2'b11 && lsu.addr[2:0] != 3'b000);
    start      = lsu.req_valid && (lsu.mem_op != MEM_OP_NONE);
    nstate     = state;
    term       = 1'b0;
    term_fault = FAULT_OK;
    case (state)
      ST_IDLE: if (start) nstate = bad_req ? ST_RESP : ST_BUSY;
      ST_BUSY: begin
        if (lsu.bus_err) begin
          term = 1'b1; term_fault = FAULT_BUS;
        end else if (lsu.bus_ack) begin
          term = 1'b1; term_fault = FAULT_OK;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          term = 1'b1; term_fault = FAULT_TMO;
        end
        if (term) nstate = ST_RESP;
      end
      default: nstate = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ST_IDLE;
    else     state <= nstate;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl_q <= '0; off_q <= '0; cnt <= '0;
      bus_req_q <= 1'b0; bus_re_q <= 1'b0; bus_we_q <= '0;
      bus_addr_q <= '0; bus_wdata_q <= '0; rdata_q <= '0; fault_q <= FAULT_OK;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          ctl_q   <= '{is_load: is_ld, sel: lsu.mem_sel, rd: lsu.rd_in};
          off_q   <= lsu.addr[OFFW-1:0];
          rdata_q <= '0;
          fault_q <= FAULT_ILL;
          if (!bad_req) begin
            bus_req_q   <= 1'b1;
            bus_re_q    <= is_ld;
            bus_we_q    <= is_st ? al_we : '0;
            bus_addr_q  <= {lsu.addr[XLEN-1:OFFW], {OFFW{1'b0}}};
            bus_wdata_q <= is_st ? al_wdata : '0;
          end
        end
        ST_BUSY: begin
          cnt <= cnt + 1'b1;
          if (term) begin
            cnt       <= '0;
            bus_req_q <= 1'b0;
            bus_re_q  <= 1'b0;
            bus_we_q  <= '0;
            fault_q   <= term_fault;
            rdata_q   <= (term_fault == FAULT_OK && ctl_q.is_load) ? al_rdata : '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign lsu.req_ready  = state == ST_IDLE;
  assign lsu.stall      = state != ST_IDLE;
  assign lsu.resp_valid = state == ST_RESP;
  assign lsu.resp_rdata = lsu.resp_valid ? rdata_q : '0;
  assign lsu.resp_fault = lsu.resp_valid ? fault_q : FAULT_OK;
  assign lsu.resp_rd    = lsu.resp_valid ? ctl_q.rd : 5'd0;
  assign lsu.bus_req    = bus_req_q;
  assign lsu.bus_re     = bus_re_q;
  assign lsu.bus_we     = bus_we_q;
  assign lsu.bus_addr   = bus_addr_q;
  assign lsu.bus_wdata  = bus_wdata_q;
endmodule
